// File: rtl/boid_pixel_writer.sv
// Purpose: erases a boid's SIZExSIZE square at its previous position, then draws it at the current position.
// Latency: the first pixel is presented the cycle after start, then one pixel per cycle; done follows the last pixel.
// Backpressure: wr_req/wr_addr/wr_data hold while wr_ack is low; clipped pixels use one idle cycle each.
module boid_pixel_writer #(
    parameter int          SIZE     = 2,
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] px,
    input  logic [31:0] py,
    input  logic [7:0]  color,
    output logic        wr_req,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_dx;
    logic [2:0]  r_dy;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_px;
    logic [15:0] r_py;
    logic [7:0]  r_color;
    logic        r_wr_req;
    logic [18:0] r_wr_addr;
    logic [7:0]  r_wr_data;

    logic        w_same;
    logic        w_last;
    logic        w_adv;
    logic [2:0]  w_nx;
    logic [2:0]  w_ny;
    logic [15:0] w_base_col;
    logic [15:0] w_base_row;
    logic [2:0]  w_dx;
    logic [2:0]  w_dy;
    logic [7:0]  w_color;
    logic [16:0] w_col;
    logic [16:0] w_row;
    logic        w_in;
    logic [18:0] w_col19;
    logic [18:0] w_row19;
    logic [18:0] w_addr;

    // Fraction bits are truncated away; only the integer halves are used.
    logic w_unused_frac;
    assign w_unused_frac = ^{x[15:0], y[15:0], px[15:0], py[15:0]};

    // An unmoved boid needs no erase: the draw overwrites the same square.
    assign w_same = (px[31:16] == x[31:16]) && (py[31:16] == y[31:16]);
    assign w_last = (r_dx == LAST) && (r_dy == LAST);
    // A walk step retires when the pixel was clipped or its write was accepted.
    assign w_adv  = ((r_state == S_ERASE) || (r_state == S_DRAW)) && (!r_wr_req || wr_ack);
    assign w_nx   = (r_dx == LAST) ? 3'd0 : r_dx + 3'd1;
    assign w_ny   = (r_dx == LAST) ? r_dy + 3'd1 : r_dy;

    // Select base corner, offset and colour of the pixel to present next.
    always_comb begin
        w_base_col = r_x;
        w_base_row = r_y;
        w_dx       = 3'd0;
        w_dy       = 3'd0;
        w_color    = r_color;
        case (r_state)
            S_IDLE: begin
                if (w_same) begin
                    w_base_col = x[31:16];
                    w_base_row = y[31:16];
                    w_color    = color;
                end else begin
                    w_base_col = px[31:16];
                    w_base_row = py[31:16];
                    w_color    = BG_COLOR;
                end
            end
            S_ERASE: begin
                // After the last erase pixel the defaults give the first draw pixel.
                if (!w_last) begin
                    w_base_col = r_px;
                    w_base_row = r_py;
                    w_color    = BG_COLOR;
                    w_dx       = w_nx;
                    w_dy       = w_ny;
                end
            end
            S_DRAW: begin
                w_dx = w_nx;
                w_dy = w_ny;
            end
            default: ;
        endcase
    end

    // Sign-extended pixel position, clip test and linear framebuffer address.
    assign w_col   = {w_base_col[15], w_base_col} + {14'd0, w_dx};
    assign w_row   = {w_base_row[15], w_base_row} + {14'd0, w_dy};
    assign w_in    = !w_col[16] && !w_row[16] && (w_col < 17'(H_RES)) && (w_row < 17'(V_RES));
    assign w_col19 = {3'd0, w_col[15:0]};
    assign w_row19 = {3'd0, w_row[15:0]};
    assign w_addr  = (H_RES == 640) ? (w_row19 << 9) + (w_row19 << 7) + w_col19
                                    : w_row19 * 19'(H_RES) + w_col19;

    // Sequencer: latch on start, walk erase then draw, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dx      <= 3'd0;
            r_dy      <= 3'd0;
            r_x       <= 16'd0;
            r_y       <= 16'd0;
            r_px      <= 16'd0;
            r_py      <= 16'd0;
            r_color   <= 8'd0;
            r_wr_req  <= 1'b0;
            r_wr_addr <= 19'd0;
            r_wr_data <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x       <= x[31:16];
                        r_y       <= y[31:16];
                        r_px      <= px[31:16];
                        r_py      <= py[31:16];
                        r_color   <= color;
                        r_state   <= w_same ? S_DRAW : S_ERASE;
                        r_dx      <= w_dx;
                        r_dy      <= w_dy;
                        r_wr_req  <= w_in;
                        r_wr_data <= w_color;
                        if (w_in) r_wr_addr <= w_addr;
                    end
                end
                S_ERASE: begin
                    if (w_adv) begin
                        if (w_last) r_state <= S_DRAW;
                        r_dx      <= w_dx;
                        r_dy      <= w_dy;
                        r_wr_req  <= w_in;
                        r_wr_data <= w_color;
                        if (w_in) r_wr_addr <= w_addr;
                    end
                end
                S_DRAW: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state  <= S_DONE;
                            r_wr_req <= 1'b0;
                        end else begin
                            r_dx      <= w_dx;
                            r_dy      <= w_dy;
                            r_wr_req  <= w_in;
                            r_wr_data <= w_color;
                            if (w_in) r_wr_addr <= w_addr;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_req  = r_wr_req;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Directed bench for boid_pixel_writer with SIZE=2 on a 640x480 framebuffer.
// Cycle k of an operation is the period after the k-1'th edge following the start edge.
// Outputs are sampled on the falling edge; inputs are driven there as well.
module tb_boid_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x, y, px, py;
    logic [7:0]  color;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    int wq_addr[$];
    int wq_data[$];
    int done_cyc, idle_cyc, gaps, hold_ok, done_n, busy1, pre_writes;

    boid_pixel_writer #(.SIZE(2), .H_RES(640), .V_RES(480), .BG_COLOR(8'h00)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x       (x),
        .y       (y),
        .px      (px),
        .py      (py),
        .color   (color),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation: ack held low for the first ack_low cycles, optional
    // spurious start (with altered inputs) at cycle spur_cyc.
    task automatic run_op(input int ack_low, input int spur_cyc, input int hold_addr);
        wq_addr.delete();
        wq_data.delete();
        done_cyc = 0; idle_cyc = 0; gaps = 0; hold_ok = 0; done_n = 0; busy1 = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            start  = (k == spur_cyc);
            if (k == spur_cyc) begin
                x     = 32'h012C0000;
                color = 8'hFF;
            end
            wr_ack = (k <= ack_low) ? 1'b0 : 1'b1;
            if (k == 1) busy1 = busy;
            if (wr_req && wr_ack) begin
                wq_addr.push_back(int'(wr_addr));
                wq_data.push_back(int'(wr_data));
            end
            if (wr_req && !wr_ack && int'(wr_addr) == hold_addr && wr_data == 8'h00) hold_ok++;
            if (busy && !done && !wr_req) gaps++;
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (!busy && idle_cyc == 0) idle_cyc = k;
            if (idle_cyc != 0 && k >= idle_cyc + 2) break;
        end
        chk("op_finished", 32'(idle_cyc != 0), 32'd1);
        start  = 1'b0;
        wr_ack = 1'b1;
    endtask

    task automatic chk_basic_writes(input string tag);
        int ea[8];
        int ed[8];
        ea = '{32098, 32099, 32738, 32739, 32100, 32101, 32740, 32741};
        ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
        chk({tag, "_count"}, 32'(wq_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq_addr.size()) begin
                chk({tag, "_addr"}, 32'(wq_addr[i]), 32'(ea[i]));
                chk({tag, "_data"}, 32'(wq_data[i]), 32'(ed[i]));
            end
        end
    endtask

    task automatic set_basic();
        x = 32'h00640000; y = 32'h00320000;
        px = 32'h00620000; py = 32'h00320000;
        color = 8'hE0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_ack = 1'b1;
        x = '0; y = '0; px = '0; py = '0; color = '0;
        repeat (2) @(negedge clk);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic erase + draw
        set_basic();
        run_op(0, 0, -1);
        chk_basic_writes("basic");
        chk("basic_busy_c1", 32'(busy1), 32'd1);
        chk("basic_done_cyc", 32'(done_cyc), 32'd9);
        chk("basic_idle_cyc", 32'(idle_cyc), 32'd10);
        chk("basic_done_n", 32'(done_n), 32'd1);
        chk("basic_gaps", 32'(gaps), 32'd0);

        // Bottom-right corner clip, erase from (0,0)
        x = 32'h027F0000; y = 32'h01DF0000; px = 32'h0; py = 32'h0; color = 8'h1C;
        run_op(0, 0, -1);
        chk("corner_count", 32'(wq_addr.size()), 32'd5);
        if (wq_addr.size() == 5) begin
            chk("corner_erase3", 32'(wq_addr[3]), 32'd641);
            chk("corner_addr", 32'(wq_addr[4]), 32'd307199);
            chk("corner_data", 32'(wq_data[4]), 32'h1C);
        end
        chk("corner_gaps", 32'(gaps), 32'd3);
        chk("corner_done_cyc", 32'(done_cyc), 32'd9);

        // Negative column and fraction truncation, no erase
        x = 32'hFFFF8000; y = 32'h0000FFFF; px = 32'hFFFF8000; py = 32'h0000FFFF; color = 8'h5A;
        run_op(0, 0, -1);
        chk("neg_count", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() == 2) begin
            chk("neg_addr0", 32'(wq_addr[0]), 32'd0);
            chk("neg_addr1", 32'(wq_addr[1]), 32'd640);
            chk("neg_data", 32'(wq_data[1]), 32'h5A);
        end
        chk("neg_gaps", 32'(gaps), 32'd2);
        chk("neg_done_cyc", 32'(done_cyc), 32'd5);

        // Backpressure on the first erase pixel
        set_basic();
        run_op(3, 0, 32098);
        chk_basic_writes("bp");
        chk("bp_hold", 32'(hold_ok), 32'd3);
        chk("bp_done_cyc", 32'(done_cyc), 32'd12);
        chk("bp_idle_cyc", 32'(idle_cyc), 32'd13);

        // Same position, spurious start while busy
        x = 32'h000A0000; y = 32'h00140000; px = 32'h000A8000; py = 32'h00140001; color = 8'h33;
        run_op(0, 2, -1);
        chk("same_count", 32'(wq_addr.size()), 32'd4);
        if (wq_addr.size() == 4) begin
            chk("same_addr0", 32'(wq_addr[0]), 32'd12810);
            chk("same_addr3", 32'(wq_addr[3]), 32'd13451);
            chk("same_data", 32'(wq_data[2]), 32'h33);
        end
        chk("same_done_cyc", 32'(done_cyc), 32'd5);
        chk("same_idle_cyc", 32'(idle_cyc), 32'd6);

        // Asynchronous reset mid-draw, after the 2nd draw write
        set_basic();
        pre_writes = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < 7 && wr_req && wr_ack) pre_writes++;
        end
        chk("rstmid_pre_writes", 32'(pre_writes), 32'd6);
        chk("rstmid_req_before", 32'(wr_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_wr_req", 32'(wr_req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_idle_req", 32'(wr_req), 32'd0);
        chk("rstmid_idle_busy", 32'(busy), 32'd0);
        run_op(0, 0, -1);
        chk_basic_writes("rerun");
        chk("rerun_done_cyc", 32'(done_cyc), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
